l1ca_channel_ctrl: RTL and testbench
====================================

Name: l1ca_channel_ctrl

Overview:
Per-channel sequencer for the L1 C/A code generator. It accepts a satellite (SV) selection over a valid/ready handshake and looks up that SV's G2 tap pair in an internal ROM. It then drives the generator's set, enable and tap inputs, and tracks code phase (chip index, 1 ms epoch, 20 ms bit edge). An SV change requested while running takes effect at the next code epoch, so the code is never truncated mid-period.

Parameters:
NUM_SVS, 32, number of valid SV codes; req_sv values >= NUM_SVS are rejected
CODE_LEN, 1023, chips per code period
MS_PER_BIT, 20, code epochs per navigation bit

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
req_valid  in  1  SV request valid
req_sv  in  6  requested SV, zero-based (0 = PRN 1)
req_ready  out  1  request accepted when req_valid && req_ready
stop  in  1  abort channel, return to IDLE
chip_tick  in  1  chip-rate strobe from code NCO; at most one per two clk cycles
gen_set  out  1  one-cycle load pulse to generator (G1/G2 to all ones)
gen_en  out  1  generator advance enable, = chip_tick while RUN
gen_taps  out  [0:9]  G2 tap select; bit (tap-1) set for each of the two taps
code_valid  out  1  generator output is a valid code chip
cur_sv  out  6  SV currently being generated
chip_idx  out  10  current chip index 0..CODE_LEN-1
ms_idx  out  5  epoch count within bit, 0..MS_PER_BIT-1
epoch  out  1  one-cycle pulse on chip_idx wrap CODE_LEN-1 -> 0
bit_edge  out  1  one-cycle pulse when epoch coincides with ms_idx wrap to 0
err  out  1  one-cycle pulse on rejected request
tick_drop  out  1  sticky: a chip_tick arrived during LOAD; cleared by stop or reset

Behaviour:
- Reset (rst=0, async): state IDLE. All outputs 0 except req_ready=1. No pending request.
- Tap ROM, PRN 1..32 as (t1,t2):
  2,6 3,7 4,8 5,9 1,9 2,10 1,8 2,9 3,10 2,3 3,4 5,6 6,7 7,8 8,9 9,10
  1,4 2,5 3,6 4,7 5,8 6,9 1,3 4,6 5,7 6,8 7,9 8,10 1,6 2,7 3,8 4,9
- gen_taps is registered from the latched SV and held stable throughout LOAD and RUN.
- IDLE:
  - req_ready=1, code_valid=0, gen_en=0.
  - Accepted request with req_sv < NUM_SVS: latch the SV into cur_sv and go to LOAD.
  - Accepted request with req_sv >= NUM_SVS: err=1 for one cycle, stay in IDLE.
- LOAD (exactly 1 cycle):
  - gen_set=1; chip_idx=0; ms_idx=0.
  - chip_tick is ignored and sets tick_drop.
  - Next state is RUN.
- RUN:
  - code_valid=1; gen_en=chip_tick.
  - Each chip_tick advances chip_idx. At CODE_LEN-1 it wraps to 0 with epoch=1 and ms_idx increments; ms_idx wraps MS_PER_BIT-1 -> 0 with bit_edge=1 in the same cycle.
  - req_ready = !pending. An accepted valid request latches pending_sv; an invalid one pulses err and does not set pending.
  - On the wrap tick with pending set: epoch still pulses, then go to LOAD using pending_sv and clear pending. cur_sv updates on LOAD entry.
- stop (any state, highest priority):
  - Next cycle: IDLE, code_valid=0, pending cleared, tick_drop cleared, counters 0.
  - A request presented in the same cycle as stop is not accepted (req_ready is forced to 0 that cycle).
- First-chip latency: request accept -> LOAD next cycle -> RUN the cycle after. The first chip_tick in RUN advances chip_idx to 1.

Test Plan:
1. Reset, then request req_sv=0 -> LOAD pulse with gen_set=1 and gen_taps=0100010000; RUN begins; generator first 10 chips read 1100100000 (octal 1440).
2. RUN PRN 1 with chip_tick every 2 clk for 1023 ticks -> exactly one epoch pulse, chip_idx 1022->0, ms_idx 0->1; after 20 epochs, bit_edge pulses once with ms_idx=0.
3. Request req_sv=31 at chip_idx=500 -> req_ready drops; switch occurs only after the wrap tick; cur_sv=31 and gen_taps=0001000010; second request at that time is stalled (req_ready=0).
4. Request req_sv=40 in IDLE and again in RUN -> err pulses once each, state and cur_sv unchanged, no pending.
5. Assert stop at chip_idx=300 with a request pending -> IDLE next cycle; code_valid, chip_idx and pending all 0; req_ready=1.
6. Assert chip_tick during the LOAD cycle -> tick_drop=1 and stays set; chip_idx unaffected; tick_drop cleared by stop.
7. Deassert rst mid-RUN asynchronously (no clock edge) -> outputs reach their reset values immediately.

Source files
------------

// File: rtl/l1ca_channel_ctrl.sv
// Per-channel sequencer for the L1 C/A code generator: SV selection, G2 tap lookup,
// generator load/advance control and code-phase tracking (chip, epoch, bit edge).
module l1ca_channel_ctrl #(
  parameter int NUM_SVS    = 32,
  parameter int CODE_LEN   = 1023,
  parameter int MS_PER_BIT = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [5:0]  req_sv,
  output logic        req_ready,
  input  logic        stop,
  input  logic        chip_tick,
  output logic        gen_set,
  output logic        gen_en,
  output logic [0:9]  gen_taps,
  output logic        code_valid,
  output logic [5:0]  cur_sv,
  output logic [9:0]  chip_idx,
  output logic [4:0]  ms_idx,
  output logic        epoch,
  output logic        bit_edge,
  output logic        err,
  output logic        tick_drop
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_e;

  state_e      state_q;
  logic        pending_q;
  logic [5:0]  pending_sv_q;
  logic [5:0]  cur_sv_q;
  logic [0:9]  taps_q;
  logic [9:0]  chip_q;
  logic [4:0]  ms_q;
  logic        gen_set_q, code_valid_q, epoch_q, bit_edge_q, err_q, tick_drop_q;

  logic        accept;
  logic        sv_ok;
  logic        last_chip;
  logic        last_ms;
  logic [5:0]  sv_sel_d;
  logic [0:9]  taps_d;

  // G2 tap pair per PRN, packed as two hex digits {t1, t2}; bit (tap-1) of the mask is set.
  function automatic logic [0:9] tap_lookup(input logic [4:0] sv);
    logic [7:0] pair;
    logic [0:9] mask;
    case (sv)
      5'd0:  pair = 8'h26;  5'd1:  pair = 8'h37;  5'd2:  pair = 8'h48;  5'd3:  pair = 8'h59;
      5'd4:  pair = 8'h19;  5'd5:  pair = 8'h2A;  5'd6:  pair = 8'h18;  5'd7:  pair = 8'h29;
      5'd8:  pair = 8'h3A;  5'd9:  pair = 8'h23;  5'd10: pair = 8'h34;  5'd11: pair = 8'h56;
      5'd12: pair = 8'h67;  5'd13: pair = 8'h78;  5'd14: pair = 8'h89;  5'd15: pair = 8'h9A;
      5'd16: pair = 8'h14;  5'd17: pair = 8'h25;  5'd18: pair = 8'h36;  5'd19: pair = 8'h47;
      5'd20: pair = 8'h58;  5'd21: pair = 8'h69;  5'd22: pair = 8'h13;  5'd23: pair = 8'h46;
      5'd24: pair = 8'h57;  5'd25: pair = 8'h68;  5'd26: pair = 8'h79;  5'd27: pair = 8'h8A;
      5'd28: pair = 8'h16;  5'd29: pair = 8'h27;  5'd30: pair = 8'h38;
      default: pair = 8'h49;
    endcase
    mask = '0;
    mask[pair[7:4] - 4'd1] = 1'b1;
    mask[pair[3:0] - 4'd1] = 1'b1;
    return mask;
  endfunction

  // A request arriving together with stop must never be taken.
  assign req_ready = !stop && ((state_q == IDLE) || (state_q == RUN && !pending_q));
  assign accept    = req_valid && req_ready;
  assign sv_ok     = int'(req_sv) < NUM_SVS;
  assign last_chip = (chip_q == 10'(CODE_LEN - 1));
  assign last_ms   = (ms_q == 5'(MS_PER_BIT - 1));
  assign sv_sel_d  = (state_q == IDLE) ? req_sv : pending_sv_q;
  assign taps_d    = tap_lookup(sv_sel_d[4:0]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      pending_q    <= 1'b0;
      pending_sv_q <= '0;
      cur_sv_q     <= '0;
      taps_q       <= '0;
      chip_q       <= '0;
      ms_q         <= '0;
      gen_set_q    <= 1'b0;
      code_valid_q <= 1'b0;
      epoch_q      <= 1'b0;
      bit_edge_q   <= 1'b0;
      err_q        <= 1'b0;
      tick_drop_q  <= 1'b0;
    end else begin
      gen_set_q  <= 1'b0;
      epoch_q    <= 1'b0;
      bit_edge_q <= 1'b0;
      err_q      <= 1'b0;
      if (stop) begin
        state_q      <= IDLE;
        code_valid_q <= 1'b0;
        pending_q    <= 1'b0;
        tick_drop_q  <= 1'b0;
        chip_q       <= '0;
        ms_q         <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (accept) begin
              if (sv_ok) begin
                state_q   <= LOAD;
                cur_sv_q  <= req_sv;
                taps_q    <= taps_d;
                gen_set_q <= 1'b1;
                chip_q    <= '0;
                ms_q      <= '0;
              end else begin
                err_q <= 1'b1;
              end
            end
          end
          LOAD: begin
            state_q      <= RUN;
            code_valid_q <= 1'b1;
            if (chip_tick) tick_drop_q <= 1'b1;
          end
          RUN: begin
            if (accept) begin
              if (sv_ok) begin
                pending_q    <= 1'b1;
                pending_sv_q <= req_sv;
              end else begin
                err_q <= 1'b1;
              end
            end
            if (chip_tick) begin
              if (last_chip) begin
                chip_q  <= '0;
                epoch_q <= 1'b1;
                if (last_ms) begin
                  ms_q       <= '0;
                  bit_edge_q <= 1'b1;
                end else begin
                  ms_q <= ms_q + 5'd1;
                end
                // Pending SV switch happens only here, so a code period is never cut short.
                if (pending_q) begin
                  state_q      <= LOAD;
                  cur_sv_q     <= pending_sv_q;
                  taps_q       <= taps_d;
                  pending_q    <= 1'b0;
                  gen_set_q    <= 1'b1;
                  code_valid_q <= 1'b0;
                  ms_q         <= '0;
                end
              end else begin
                chip_q <= chip_q + 10'd1;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign gen_en     = (state_q == RUN) && chip_tick;
  assign gen_set    = gen_set_q;
  assign gen_taps   = taps_q;
  assign code_valid = code_valid_q;
  assign cur_sv     = cur_sv_q;
  assign chip_idx   = chip_q;
  assign ms_idx     = ms_q;
  assign epoch      = epoch_q;
  assign bit_edge   = bit_edge_q;
  assign err        = err_q;
  assign tick_drop  = tick_drop_q;

endmodule

// File: tb/tb_l1ca_channel_ctrl.sv
// Self-checking bench for l1ca_channel_ctrl: vector table, directed phase/switch/stop/reset
// sequences and randomized traffic against a tick-count based reference model.
module tb_l1ca_channel_ctrl;

  localparam int NUM_SVS    = 32;
  localparam int CODE_LEN   = 1023;
  localparam int MS_PER_BIT = 20;
  localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_valid = 1'b0;
  logic [5:0] req_sv = '0;
  logic       stop = 1'b0;
  logic       chip_tick = 1'b0;
  logic       req_ready, gen_set, gen_en, code_valid, epoch, bit_edge, err, tick_drop;
  logic [0:9] gen_taps;
  logic [5:0] cur_sv;
  logic [9:0] chip_idx;
  logic [4:0] ms_idx;

  l1ca_channel_ctrl #(.NUM_SVS(NUM_SVS), .CODE_LEN(CODE_LEN), .MS_PER_BIT(MS_PER_BIT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_sv(req_sv), .req_ready(req_ready),
    .stop(stop), .chip_tick(chip_tick), .gen_set(gen_set), .gen_en(gen_en),
    .gen_taps(gen_taps), .code_valid(code_valid), .cur_sv(cur_sv), .chip_idx(chip_idx),
    .ms_idx(ms_idx), .epoch(epoch), .bit_edge(bit_edge), .err(err), .tick_drop(tick_drop)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Tap pairs copied from the GPS ICD table, PRN 1..32.
  int tapA[32] = '{2,3,4,5,1,2,1,2,3,2,3,5,6,7,8,9,1,2,3,4,5,6,1,4,5,6,7,8,1,2,3,4};
  int tapB[32] = '{6,7,8,9,9,10,8,9,10,3,4,6,7,8,9,10,4,5,6,7,8,9,3,6,7,8,9,10,6,7,8,9};

  // Reference model: phase is kept as a plain count of chip ticks since the last load.
  int         mState, mSv, mPendSv, mTicks;
  bit         mPending, mDrop, mSet, mEpoch, mBit, mErr;
  logic [0:9] mTaps;

  function automatic logic [0:9] tapMask(input int sv);
    logic [0:9] m;
    m = '0;
    m[tapA[sv] - 1] = 1'b1;
    m[tapB[sv] - 1] = 1'b1;
    return m;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mState = M_IDLE; mSv = 0; mPendSv = 0; mTicks = 0;
    mPending = 0; mDrop = 0; mSet = 0; mEpoch = 0; mBit = 0; mErr = 0;
    mTaps = '0;
  endtask

  task automatic checkModel();
    checkOutput("code_valid", code_valid, mState == M_RUN);
    checkOutput("gen_set", gen_set, mSet);
    checkOutput("cur_sv", cur_sv, mSv);
    checkOutput("gen_taps", gen_taps, mTaps);
    checkOutput("chip_idx", chip_idx, mTicks % CODE_LEN);
    checkOutput("ms_idx", ms_idx, (mTicks / CODE_LEN) % MS_PER_BIT);
    checkOutput("epoch", epoch, mEpoch);
    checkOutput("bit_edge", bit_edge, mBit);
    checkOutput("err", err, mErr);
    checkOutput("tick_drop", tick_drop, mDrop);
  endtask

  // One clock cycle: drive inputs, check combinational outputs, advance model, check registers.
  task automatic applyStimulus(input bit v, input int sv, input bit s, input bit t,
                               output bit preReady);
    bit ready, accept, oldPend;
    req_valid = v; req_sv = 6'(sv); stop = s; chip_tick = t;
    #1;
    ready = !s && (mState == M_IDLE || (mState == M_RUN && !mPending));
    preReady = req_ready;
    checkOutput("req_ready", req_ready, ready);
    checkOutput("gen_en", gen_en, (mState == M_RUN) && t);
    accept = v && ready;
    oldPend = mPending;
    mSet = 0; mEpoch = 0; mBit = 0; mErr = 0;
    if (s) begin
      mState = M_IDLE; mPending = 0; mDrop = 0; mTicks = 0;
    end else if (mState == M_IDLE) begin
      if (accept && sv < NUM_SVS) begin
        mState = M_LOAD; mSv = sv; mTaps = tapMask(sv); mSet = 1; mTicks = 0;
      end else if (accept) mErr = 1;
    end else if (mState == M_LOAD) begin
      if (t) mDrop = 1;
      mState = M_RUN;
    end else begin
      if (accept && sv < NUM_SVS) begin
        mPending = 1; mPendSv = sv;
      end else if (accept) mErr = 1;
      if (t) begin
        mTicks++;
        if (mTicks % CODE_LEN == 0) begin
          mEpoch = 1;
          if ((mTicks / CODE_LEN) % MS_PER_BIT == 0) mBit = 1;
          if (oldPend) begin
            mState = M_LOAD; mSv = mPendSv; mTaps = tapMask(mPendSv);
            mPending = 0; mSet = 1; mTicks = 0;
          end
        end
      end
    end
    @(posedge clk);
    #1;
    req_valid = 0; stop = 0; chip_tick = 0;
    checkModel();
  endtask

  task automatic runTicks(input int n);
    bit r;
    for (int i = 0; i < n; i++) begin
      applyStimulus(0, 0, 0, 1, r);
      applyStimulus(0, 0, 0, 0, r);
    end
  endtask

  typedef struct {
    bit v; int sv; bit s; bit t;
    bit eReady; bit eSet; bit eValid; int eSv; logic [0:9] eTaps; int eChip; bit eErr; bit eDrop;
  } vec_t;

  vec_t vecs[16];

  initial begin
    bit r;
    int epochCnt, bitCnt;
    bit lastTick;
    logic [0:9] p1, p32;
    p1  = 10'b0100010000;
    p32 = 10'b0001000010;

    vecs[0]  = '{1, 0, 0, 0,  1, 1, 0, 0,  p1,  0, 0, 0};
    vecs[1]  = '{0, 0, 0, 0,  0, 0, 1, 0,  p1,  0, 0, 0};
    vecs[2]  = '{0, 0, 0, 1,  1, 0, 1, 0,  p1,  1, 0, 0};
    vecs[3]  = '{0, 0, 0, 0,  1, 0, 1, 0,  p1,  1, 0, 0};
    vecs[4]  = '{0, 0, 0, 1,  1, 0, 1, 0,  p1,  2, 0, 0};
    vecs[5]  = '{1, 40, 0, 0, 1, 0, 1, 0,  p1,  2, 1, 0};
    vecs[6]  = '{0, 0, 0, 0,  1, 0, 1, 0,  p1,  2, 0, 0};
    vecs[7]  = '{1, 5, 0, 0,  1, 0, 1, 0,  p1,  2, 0, 0};
    vecs[8]  = '{1, 7, 0, 0,  0, 0, 1, 0,  p1,  2, 0, 0};
    vecs[9]  = '{1, 3, 1, 0,  0, 0, 0, 0,  p1,  0, 0, 0};
    vecs[10] = '{0, 0, 0, 0,  1, 0, 0, 0,  p1,  0, 0, 0};
    vecs[11] = '{1, 31, 0, 0, 1, 1, 0, 31, p32, 0, 0, 0};
    vecs[12] = '{0, 0, 0, 1,  0, 0, 1, 31, p32, 0, 0, 1};
    vecs[13] = '{0, 0, 0, 0,  1, 0, 1, 31, p32, 0, 0, 1};
    vecs[14] = '{0, 0, 0, 1,  1, 0, 1, 31, p32, 1, 0, 1};
    vecs[15] = '{0, 0, 1, 0,  0, 0, 0, 31, p32, 0, 0, 0};

    modelReset();
    #12;
    checkOutput("reset req_ready", req_ready, 1);
    checkModel();
    @(posedge clk);
    #1 rst = 1'b1;

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].v, vecs[i].sv, vecs[i].s, vecs[i].t, r);
      checkOutput($sformatf("vec%0d ready", i), r, vecs[i].eReady);
      checkOutput($sformatf("vec%0d gen_set", i), gen_set, vecs[i].eSet);
      checkOutput($sformatf("vec%0d code_valid", i), code_valid, vecs[i].eValid);
      checkOutput($sformatf("vec%0d cur_sv", i), cur_sv, vecs[i].eSv);
      checkOutput($sformatf("vec%0d gen_taps", i), gen_taps, vecs[i].eTaps);
      checkOutput($sformatf("vec%0d chip_idx", i), chip_idx, vecs[i].eChip);
      checkOutput($sformatf("vec%0d err", i), err, vecs[i].eErr);
      checkOutput($sformatf("vec%0d tick_drop", i), tick_drop, vecs[i].eDrop);
    end

    // Twenty full code periods of PRN 1: one epoch per period, one bit edge at the end.
    applyStimulus(1, 0, 0, 0, r);
    applyStimulus(0, 0, 0, 0, r);
    epochCnt = 0; bitCnt = 0;
    for (int k = 0; k < CODE_LEN * MS_PER_BIT; k++) begin
      applyStimulus(0, 0, 0, 1, r);
      if (epoch) epochCnt++;
      if (bit_edge) begin
        bitCnt++;
        checkOutput("ms at bit edge", ms_idx, 0);
      end
      if (k == CODE_LEN - 1) begin
        checkOutput("first epoch pulse", epoch, 1);
        checkOutput("first epoch chip", chip_idx, 0);
        checkOutput("first epoch ms", ms_idx, 1);
      end
      applyStimulus(0, 0, 0, 0, r);
    end
    checkOutput("epoch count", epochCnt, MS_PER_BIT);
    checkOutput("bit_edge count", bitCnt, 1);

    // SV switch requested mid-period waits for the wrap tick.
    runTicks(500);
    applyStimulus(1, 31, 0, 0, r);
    checkOutput("switch req accepted", r, 1);
    applyStimulus(1, 5, 0, 0, r);
    checkOutput("second req stalled", r, 0);
    runTicks(522);
    checkOutput("sv before wrap", cur_sv, 0);
    checkOutput("chip before wrap", chip_idx, 1022);
    applyStimulus(0, 0, 0, 1, r);
    checkOutput("switch epoch", epoch, 1);
    checkOutput("switch gen_set", gen_set, 1);
    checkOutput("switch cur_sv", cur_sv, 31);
    checkOutput("switch taps", gen_taps, p32);
    applyStimulus(0, 0, 0, 0, r);

    // Stop mid-period with a request pending.
    runTicks(300);
    applyStimulus(1, 2, 0, 0, r);
    applyStimulus(0, 0, 1, 0, r);
    checkOutput("stop code_valid", code_valid, 0);
    checkOutput("stop chip_idx", chip_idx, 0);
    #1;
    checkOutput("stop req_ready", req_ready, 1);

    // Asynchronous reset while running, away from any clock edge.
    applyStimulus(1, 7, 0, 0, r);
    applyStimulus(0, 0, 0, 0, r);
    runTicks(10);
    #1 rst = 1'b0;
    #1;
    checkOutput("async rst code_valid", code_valid, 0);
    checkOutput("async rst chip_idx", chip_idx, 0);
    checkOutput("async rst cur_sv", cur_sv, 0);
    checkOutput("async rst gen_taps", gen_taps, 0);
    checkOutput("async rst req_ready", req_ready, 1);
    modelReset();
    @(posedge clk);
    #1 rst = 1'b1;

    lastTick = 1;
    for (int n = 0; n < 15000; n++) begin
      bit v, s, t;
      int sv;
      t = !lastTick && ($urandom_range(0, 99) < 45);
      v = ($urandom_range(0, 149) == 0);
      sv = int'($urandom_range(0, 40));
      s = ($urandom_range(0, 2999) == 0);
      lastTick = t;
      applyStimulus(v, sv, s, t, r);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
